// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the SuperFrog game controller
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Game phase as seen on the HUD / state output
  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_DYING   = 2'd2,
    ST_OVER    = 2'd3
  } game_state_t;

  // Width of one packed BCD digit
  localparam int c_BCD_W = 4;

  // Default number of BCD digits in score/hiscore
  localparam int c_SCORE_DIGITS = 4;

endpackage
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter
// Description : Multi-digit packed BCD up-counter, saturating at all 9s
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS = c_SCORE_DIGITS
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clr,
  input  logic                        i_inc,
  output logic [c_BCD_W*DIGITS-1:0]   o_value
);

  localparam logic [c_BCD_W-1:0] c_NINE = c_BCD_W'(9);
  localparam logic [c_BCD_W-1:0] c_ONE  = c_BCD_W'(1);

  logic [c_BCD_W*DIGITS-1:0] r_value;
  logic [c_BCD_W*DIGITS-1:0] w_next;
  logic [DIGITS-1:0]         w_is9;
  logic [DIGITS-1:0]         w_carry;

  // Increment is suppressed once every digit reads 9, so the count holds
  assign w_carry[0] = i_inc & ~(&w_is9);

  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      assign w_is9[d] = (r_value[d*c_BCD_W +: c_BCD_W] == c_NINE);
      assign w_next[d*c_BCD_W +: c_BCD_W] =
          w_carry[d] ? (w_is9[d] ? '0 : r_value[d*c_BCD_W +: c_BCD_W] + c_ONE)
                     : r_value[d*c_BCD_W +: c_BCD_W];
      if (d < DIGITS - 1) begin : g_carry
        // A digit rolling 9->0 carries into the next digit up
        assign w_carry[d+1] = w_carry[d] & w_is9[d];
      end
    end
  endgenerate

  // Count register: clear has priority over increment
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_value <= '0;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl
// Description : Frame-level game sequencer (attract/play/dying/over) with
//               lives, BCD survival score and high score
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES            = 3,
  parameter int SCORE_DIGITS     = c_SCORE_DIGITS,
  parameter int FRAMES_PER_POINT = 60,
  parameter int DEATH_FRAMES     = 120,
  parameter int OVER_FRAMES      = 180
) (
  input  logic                            clk_pix,
  input  logic                            rst_pix,
  input  logic                            frame,
  input  logic                            dead,
  input  logic                            btn_start,
  output logic [1:0]                      state,
  output logic                            run,
  output logic                            playfield_rst,
  output logic [2:0]                      lives,
  output logic [c_BCD_W*SCORE_DIGITS-1:0] score,
  output logic [c_BCD_W*SCORE_DIGITS-1:0] hiscore
);

  localparam int c_PH_MAX = (DEATH_FRAMES > OVER_FRAMES) ? DEATH_FRAMES : OVER_FRAMES;
  localparam int c_PH_W   = $clog2(c_PH_MAX + 1);
  localparam int c_PT_W   = $clog2(FRAMES_PER_POINT + 1);

  localparam logic [c_PH_W-1:0] c_DEATH_LAST = c_PH_W'(DEATH_FRAMES - 1);
  localparam logic [c_PH_W-1:0] c_OVER_LAST  = c_PH_W'(OVER_FRAMES - 1);
  localparam logic [c_PT_W-1:0] c_POINT_LAST = c_PT_W'(FRAMES_PER_POINT - 1);

  game_state_t                     r_state;
  logic                            r_run;
  logic                            r_playfield_rst;
  logic [2:0]                      r_lives;
  logic [c_BCD_W*SCORE_DIGITS-1:0] r_hiscore;
  logic [c_PH_W-1:0]               r_phase;
  logic [c_PT_W-1:0]               r_point;
  logic                            r_btn_prev;

  logic                            w_start_edge;
  logic                            w_point_done;
  logic                            w_score_clr;
  logic                            w_score_inc;
  logic [c_BCD_W*SCORE_DIGITS-1:0] w_score;

  assign w_start_edge = btn_start & ~r_btn_prev;
  assign w_point_done = frame & (r_point == c_POINT_LAST);
  assign w_score_clr  = (r_state == ST_ATTRACT) & w_start_edge;
  // A death on the same cycle as a completing frame forfeits that point
  assign w_score_inc  = (r_state == ST_PLAY) & ~dead & w_point_done;

  bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .i_clk   (clk_pix),
    .i_rst   (rst_pix),
    .i_clr   (w_score_clr),
    .i_inc   (w_score_inc),
    .o_value (w_score)
  );

  // Game sequencer with registered run/playfield reset/lives/hiscore
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_state         <= ST_ATTRACT;
      r_run           <= 1'b0;
      r_playfield_rst <= 1'b0;
      r_lives         <= 3'(LIVES);
      r_hiscore       <= '0;
      r_phase         <= '0;
      r_point         <= '0;
      r_btn_prev      <= 1'b1;
    end else begin
      r_btn_prev      <= btn_start;
      r_playfield_rst <= 1'b0;
      case (r_state)
        ST_ATTRACT: begin
          if (w_start_edge) begin
            r_state         <= ST_PLAY;
            r_run           <= 1'b1;
            r_playfield_rst <= 1'b1;
            r_lives         <= 3'(LIVES);
            r_point         <= '0;
          end
        end
        ST_PLAY: begin
          if (dead) begin
            r_state <= ST_DYING;
            r_run   <= 1'b0;
            r_lives <= r_lives - 3'd1;
            r_phase <= '0;
          end else if (frame) begin
            r_point <= w_point_done ? '0 : r_point + c_PT_W'(1);
          end
        end
        ST_DYING: begin
          if (frame) begin
            if (r_phase == c_DEATH_LAST) begin
              r_phase <= '0;
              if (r_lives != 3'd0) begin
                r_state         <= ST_PLAY;
                r_run           <= 1'b1;
                r_playfield_rst <= 1'b1;
              end else begin
                r_state <= ST_OVER;
                if (w_score > r_hiscore) begin
                  r_hiscore <= w_score;
                end
              end
            end else begin
              r_phase <= r_phase + c_PH_W'(1);
            end
          end
        end
        ST_OVER: begin
          if (frame) begin
            if (r_phase == c_OVER_LAST) begin
              r_phase <= '0;
              r_state <= ST_ATTRACT;
            end else begin
              r_phase <= r_phase + c_PH_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_ATTRACT;
        end
      endcase
    end
  end

  assign state         = r_state;
  assign run           = r_run;
  assign playfield_rst = r_playfield_rst;
  assign lives         = r_lives;
  assign score         = w_score;
  assign hiscore       = r_hiscore;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_ctrl
// Description : Directed self-checking bench for game_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

  logic       clk_pix = 1'b0;
  logic       rst_pix;
  logic       frame;
  logic       dead;
  logic       btn_start;
  logic [1:0] state;
  logic       run;
  logic       playfield_rst;
  logic [2:0] lives;
  logic [7:0] score;
  logic [7:0] hiscore;

  int checks = 0;
  int errors = 0;

  game_ctrl #(
    .LIVES            (2),
    .SCORE_DIGITS     (2),
    .FRAMES_PER_POINT (2),
    .DEATH_FRAMES     (3),
    .OVER_FRAMES      (4)
  ) dut (
    .clk_pix       (clk_pix),
    .rst_pix       (rst_pix),
    .frame         (frame),
    .dead          (dead),
    .btn_start     (btn_start),
    .state         (state),
    .run           (run),
    .playfield_rst (playfield_rst),
    .lives         (lives),
    .score         (score),
    .hiscore       (hiscore)
  );

  always #5 clk_pix = ~clk_pix;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // n consecutive frame strobes
  task automatic frames(input int n);
    frame = 1'b1;
    repeat (n) tick();
    frame = 1'b0;
  endtask

  task automatic press_start();
    btn_start = 1'b0;
    tick();
    btn_start = 1'b1;
    tick();
  endtask

  // Die once, wait out the death sequence
  task automatic die_and_wait();
    dead = 1'b1;
    tick();
    dead = 1'b0;
    frames(3);
  endtask

  initial begin
    rst_pix   = 1'b1;
    frame     = 1'b0;
    dead      = 1'b0;
    btn_start = 1'b1;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_run", run, 0);
    chk("rst_lives", lives, 2);
    chk("rst_score", score, 8'h00);
    chk("rst_hiscore", hiscore, 8'h00);
    chk("rst_pfrst", playfield_rst, 0);

    // Button held through reset release must not start a game
    rst_pix = 1'b0;
    repeat (4) tick();
    chk("held_btn_attract", state, 0);

    // ---------------- Game 1 ----------------
    press_start();
    chk("g1_state_play", state, 1);
    chk("g1_run", run, 1);
    chk("g1_pfrst_pulse", playfield_rst, 1);
    chk("g1_lives", lives, 2);
    chk("g1_score0", score, 8'h00);
    btn_start = 1'b0;
    tick();
    chk("g1_pfrst_one_cycle", playfield_rst, 0);

    frames(1);
    chk("g1_score_half_point", score, 8'h00);
    frames(19);
    chk("g1_bcd_carry", score, 8'h10);
    frames(1);
    chk("g1_score_timer1", score, 8'h10);

    // Death coincides with a point-completing frame: no point awarded
    dead  = 1'b1;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    dead  = 1'b0;
    chk("g1_dying", state, 2);
    chk("g1_dead_wins", score, 8'h10);
    chk("g1_lives1", lives, 1);
    chk("g1_run_dying", run, 0);
    frames(2);
    chk("g1_still_dying", state, 2);
    frames(1);
    chk("g1_replay", state, 1);
    chk("g1_replay_pfrst", playfield_rst, 1);
    chk("g1_score_kept", score, 8'h10);
    tick();
    chk("g1_replay_pfrst_end", playfield_rst, 0);
    frames(1);
    chk("g1_timer_kept", score, 8'h11);

    // Second death with dead left asserted (ignored outside PLAY)
    dead = 1'b1;
    tick();
    chk("g1_lives0", lives, 0);
    frames(3);
    dead = 1'b0;
    chk("g1_over", state, 3);
    chk("g1_hiscore", hiscore, 8'h11);
    chk("g1_lives0_hold", lives, 0);
    press_start();
    chk("g1_over_ignores_start", state, 3);
    frames(3);
    chk("g1_over_wait", state, 3);
    frames(1);
    chk("g1_attract", state, 0);
    chk("g1_score_visible", score, 8'h11);

    // ---------------- Game 2 (lower score) ----------------
    press_start();
    btn_start = 1'b0;
    chk("g2_play", state, 1);
    chk("g2_score_clr", score, 8'h00);
    chk("g2_lives", lives, 2);
    frames(4);
    chk("g2_score", score, 8'h02);
    die_and_wait();
    die_and_wait();
    chk("g2_over", state, 3);
    chk("g2_hiscore_kept", hiscore, 8'h11);
    frames(4);
    chk("g2_attract", state, 0);

    // ---------------- Game 3 (higher score, saturation) ----------------
    press_start();
    btn_start = 1'b0;
    chk("g3_play", state, 1);
    frames(198);
    chk("g3_score99", score, 8'h99);
    frames(12);
    chk("g3_saturate", score, 8'h99);
    die_and_wait();
    die_and_wait();
    chk("g3_over", state, 3);
    chk("g3_hiscore_new", hiscore, 8'h99);
    frames(4);
    chk("g3_attract", state, 0);

    // ---------------- Reset during DYING ----------------
    press_start();
    btn_start = 1'b0;
    frames(2);
    dead = 1'b1;
    tick();
    dead = 1'b0;
    chk("g4_dying", state, 2);
    rst_pix = 1'b1;
    tick();
    rst_pix = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_run", run, 0);
    chk("mid_rst_lives", lives, 2);
    chk("mid_rst_score", score, 8'h00);
    chk("mid_rst_hiscore", hiscore, 8'h00);
    chk("mid_rst_pfrst", playfield_rst, 0);
    tick();
    chk("post_rst_pfrst", playfield_rst, 0);
    chk("post_rst_attract", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
# game_ctrl

Frame-level game state controller for the SuperFrog playfield; sits directly downstream of the collision logic and consumes its sticky `dead` flag plus the display `frame` strobe. It sequences attract → play → dying → game-over, issues a one-cycle playfield reset to restart sprites, keeps lives, and maintains a BCD survival score and high score for an on-screen HUD. All outputs are registered in the pixel clock domain.

## Interface
- `LIVES`, 3: lives per game, 1..7
- `SCORE_DIGITS`, 4: BCD digits in score/hiscore
- `FRAMES_PER_POINT`, 60: frames survived per score point, ≥1
- `DEATH_FRAMES`, 120: frames spent in DYING, ≥1
- `OVER_FRAMES`, 180: frames spent in OVER, ≥1
- `clk_pix` in 1: pixel clock; the only clock
- `rst_pix` in 1: reset, synchronous, active-high
- `frame` in 1: one-cycle start-of-frame strobe
- `dead` in 1: collision flag, sticky until playfield reset
- `btn_start` in 1: start button level, already synchronised
- `state` out 2: 0 ATTRACT, 1 PLAY, 2 DYING, 3 OVER
- `run` out 1: high only in PLAY; gates sprite motion
- `playfield_rst` out 1: one-cycle pulse restarting sprites/`dead`; integration ORs with `rst_pix`
- `lives` out 3: remaining lives
- `score` out 4*SCORE_DIGITS: packed BCD, digit 0 in LSBs
- `hiscore` out 4*SCORE_DIGITS: packed BCD best score since reset

## Operation
- Reset values: state ATTRACT, run 0, playfield_rst 0, lives LIVES, score 0, hiscore 0, frame/phase timers 0, btn_prev 1.
- Start edge = `btn_start & ~btn_prev`; btn_prev resets to 1, so a button held through reset does not start a game.
- ATTRACT: on start edge → PLAY; pulse playfield_rst; score ← 0; lives ← LIVES; point timer ← 0.
- PLAY: each `frame` increments point timer; at FRAMES_PER_POINT-1 it wraps to 0 and score increments by 1 (BCD carry per digit). Score saturates at all-9s; timer keeps wrapping.
- PLAY, `dead`=1 on any cycle → DYING; lives ← lives-1; phase timer ← 0. If `dead` and point-completing `frame` coincide, dead wins: no score increment.
- DYING: count `frame` strobes; at DEATH_FRAMES: lives≠0 → PLAY with playfield_rst pulse, score and point timer kept; lives=0 → OVER, hiscore ← max(hiscore, score).
- OVER: count OVER_FRAMES `frame` strobes → ATTRACT. Start edges ignored. Score stays visible until next start.
- `dead` ignored outside PLAY. `btn_start` ignored outside ATTRACT.
- Hiscore comparison is an unsigned compare of packed BCD vectors (valid for BCD ordering).

## Timing
- All transitions take effect the cycle after the qualifying input cycle. state/run/lives/score update together.
- playfield_rst is high exactly one cycle, the same cycle `state` first reads PLAY.
- Score increment is visible the cycle after the completing `frame`.
- hiscore updates in the same cycle `state` first reads OVER.
- `rst_pix` mid-game: next cycle all outputs at reset values. No playfield_rst pulse is issued.
- Phase-timer width: $clog2(max(DEATH_FRAMES, OVER_FRAMES)+1). Point-timer width: $clog2(FRAMES_PER_POINT+1).

## Structure
- Shared package `game_pkg`: `game_state_t` enum (2-bit, values above), BCD digit width constant, `SCORE_DIGITS` default.
- Sub-module `bcd_counter`: SCORE_DIGITS-wide, with `clr` and `inc` inputs, per-digit carry, saturating at all-9s; instantiated once for score.
- Top-level FSM, timers and hiscore register live in `game_ctrl`.

## Test plan
Bench parameters: LIVES=2, FRAMES_PER_POINT=2, DEATH_FRAMES=3, OVER_FRAMES=4, SCORE_DIGITS=2.
- Hold btn_start high through reset release, with no release afterwards → stays ATTRACT. Release then press → PLAY next cycle, playfield_rst=1 for one cycle, lives=2, score=0x00.
- In PLAY, 20 frames → score=0x10, exercising BCD carry 09→10. Continue to 199 frames total → score saturates at 0x99.
- `dead`=1 on the same cycle as a point-completing frame → DYING, score unchanged, lives=1. After 3 frames → PLAY with a playfield_rst pulse.
- Second death → lives=0. After 3 frames → OVER, hiscore=score. After 4 frames → ATTRACT. A start edge during OVER has no effect.
- Second game scoring lower than the first → hiscore unchanged. Third game scoring higher → hiscore updated.
- Assert rst_pix in DYING → next cycle state=0, run=0, lives=2, score=0, hiscore=0, playfield_rst=0.
